// File: rtl/wave_pkg.sv
// Shared encodings for wave_meter and form_wave users: FORM codes and the
// measurement FSM states.
package wave_pkg;

  typedef enum logic [2:0] {
    FORM_SAW        = 3'b000,
    FORM_RSAW       = 3'b001,
    FORM_TRI        = 3'b010,
    FORM_MEANDER    = 3'b011,
    FORM_MEANDER025 = 3'b100,
    FORM_UNKNOWN    = 3'b111
  } form_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2
  } state_e;

  // Jump counters only need to tell 0, 1 and "more than one" apart.
  localparam logic [1:0] JUMP_SAT = 2'd3;

endpackage

// File: rtl/wave_classify.sv
// Purely combinational waveform classifier: maps the per-period statistics
// (count, high count, small steps, jumps) onto a FORM code.
module wave_classify
  import wave_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic [CNT_W-1:0] n,
  input  logic [CNT_W-1:0] h,
  input  logic [CNT_W-1:0] u,
  input  logic [CNT_W-1:0] d,
  input  logic [1:0]       ju,
  input  logic [1:0]       jd,
  output form_e            form
);

  // Two extra bits hold 4*H without overflow.
  localparam int W = CNT_W + 2;

  logic [W-1:0] n_x, two_h, four_h, dev2, dev4, tol;
  logic         no_small;

  always_comb begin
    n_x      = W'(n);
    two_h    = W'(h) << 1;
    four_h   = W'(h) << 2;
    dev2     = (two_h >= n_x) ? two_h - n_x : n_x - two_h;
    dev4     = (four_h >= n_x) ? four_h - n_x : n_x - four_h;
    tol      = n_x >> 3;
    no_small = (u == '0) && (d == '0);

    form = FORM_UNKNOWN;
    if (n_x < W'(4)) begin
      form = FORM_UNKNOWN;
    end else if (no_small && (dev2 <= tol)) begin
      form = FORM_MEANDER;
    end else if (no_small && (dev4 <= tol)) begin
      form = FORM_MEANDER025;
    end else if ((u != '0) && (d != '0) && (ju == 2'd0) && (jd == 2'd0)) begin
      form = FORM_TRI;
    end else if ((u != '0) && (d == '0) && (jd == 2'd1)) begin
      form = FORM_SAW;
    end else if ((d != '0) && (u == '0) && (ju == 2'd1)) begin
      form = FORM_RSAW;
    end
  end

endmodule

// File: rtl/wave_meter.sv
// Waveform meter: measures period between mid-level crossings, classifies the
// shape and tracks lock. Optional MAX/MIN tracking under WAVE_METER_MINMAX_EN.
module wave_meter
  import wave_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 65536
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] SAMPLE,
  input  logic              SAMPLE_VALID,
  output logic [CNT_W-1:0]  PERIOD,
  output logic [2:0]        FORM,
  output logic [DATA_W-1:0] MAX,
  output logic [DATA_W-1:0] MIN,
  output logic              RESULT_VALID,
  output logic              LOCKED
);

  localparam int                 TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0]    TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [DATA_W:0]    QUARTER = (DATA_W + 1)'(1) << (DATA_W - 2);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   prev_q, prev_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic [CNT_W-1:0]    n_q, n_d, h_q, h_d, u_q, u_d, d_q, d_d;
  logic [1:0]          ju_q, ju_d, jd_q, jd_d;
  logic [CNT_W-1:0]    period_q, period_d;
  form_e               form_q, form_d, cls_form;
  logic                locked_q, locked_d, rv_q, rv_d;

  logic signed [DATA_W:0] delta;
  logic [DATA_W:0]        delta_mag;
  logic crossing, high, jump, jump_up, jump_dn, small_up, small_dn;
  logic start_period, acc_en, publish;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  function automatic logic [1:0] jump_inc(input logic [1:0] v, input logic en);
    return (en && (v != JUMP_SAT)) ? v + 2'd1 : v;
  endfunction

  always_comb begin
    crossing  = !prev_q[DATA_W-1] && SAMPLE[DATA_W-1];
    high      = SAMPLE[DATA_W-1];
    delta     = $signed({1'b0, SAMPLE}) - $signed({1'b0, prev_q});
    delta_mag = delta[DATA_W] ? unsigned'(-delta) : unsigned'(delta);
    jump      = delta_mag >= QUARTER;
    jump_up   = jump && !delta[DATA_W];
    jump_dn   = jump && delta[DATA_W];
    small_up  = !jump && !delta[DATA_W] && (delta != '0);
    small_dn  = !jump && delta[DATA_W];
  end

  wave_classify #(.CNT_W(CNT_W)) u_classify (
    .n    (n_q),
    .h    (h_q),
    .u    (u_q),
    .d    (d_q),
    .ju   (ju_q),
    .jd   (jd_q),
    .form (cls_form)
  );

  always_comb begin
    // NOTE: every variable gets a default first, so no path through this block can infer a latch.
    state_d      = state_q;
    prev_d       = prev_q;
    to_d         = to_q;
    n_d          = n_q;
    h_d          = h_q;
    u_d          = u_q;
    d_d          = d_q;
    ju_d         = ju_q;
    jd_d         = jd_q;
    period_d     = period_q;
    form_d       = form_q;
    locked_d     = locked_q;
    rv_d         = 1'b0;
    start_period = 1'b0;
    acc_en       = 1'b0;
    publish      = 1'b0;

    if (SAMPLE_VALID) begin
      prev_d = SAMPLE;
      case (state_q)
        IDLE:  state_d = ARMED;
        ARMED: begin
          if (crossing) begin
            state_d      = MEASURE;
            start_period = 1'b1;
          end
        end
        MEASURE: begin
          if (crossing) begin
            publish      = 1'b1;
            start_period = 1'b1;
          end else if (to_q == TO_LAST) begin
            state_d  = ARMED;
            form_d   = FORM_UNKNOWN;
            locked_d = 1'b0;
          end else begin
            acc_en = 1'b1;
            to_d   = to_q + TO_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Lock compares the fresh classification with the previous result's FORM.
    if (publish) begin
      period_d = n_q;
      form_d   = cls_form;
      locked_d = (cls_form != FORM_UNKNOWN) && (cls_form == form_q);
      rv_d     = 1'b1;
    end

    // The crossing sample is the first sample of the new period.
    if (start_period) begin
      to_d = '0;
      n_d  = CNT_W'(1);
      h_d  = CNT_W'(high);
      u_d  = CNT_W'(small_up);
      d_d  = CNT_W'(small_dn);
      ju_d = {1'b0, jump_up};
      jd_d = {1'b0, jump_dn};
    end else if (acc_en) begin
      n_d  = sat_inc(n_q, 1'b1);
      h_d  = sat_inc(h_q, high);
      u_d  = sat_inc(u_q, small_up);
      d_d  = sat_inc(d_q, small_dn);
      ju_d = jump_inc(ju_q, jump_up);
      jd_d = jump_inc(jd_q, jump_dn);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    // NOTE: every flop, accumulators included, is reset so a partial period never survives RESET.
    if (RESET) begin
      state_q  <= IDLE;
      prev_q   <= '0;
      to_q     <= '0;
      n_q      <= '0;
      h_q      <= '0;
      u_q      <= '0;
      d_q      <= '0;
      ju_q     <= '0;
      jd_q     <= '0;
      period_q <= '0;
      form_q   <= FORM_UNKNOWN;
      locked_q <= 1'b0;
      rv_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      prev_q   <= prev_d;
      to_q     <= to_d;
      n_q      <= n_d;
      h_q      <= h_d;
      u_q      <= u_d;
      d_q      <= d_d;
      ju_q     <= ju_d;
      jd_q     <= jd_d;
      period_q <= period_d;
      form_q   <= form_d;
      locked_q <= locked_d;
      rv_q     <= rv_d;
    end
  end

`ifdef WAVE_METER_MINMAX_EN
  logic [DATA_W-1:0] max_acc_q, max_acc_d, min_acc_q, min_acc_d;
  logic [DATA_W-1:0] max_q, max_d, min_q, min_d;

  always_comb begin
    max_acc_d = max_acc_q;
    min_acc_d = min_acc_q;
    max_d     = max_q;
    min_d     = min_q;
    if (publish) begin
      max_d = max_acc_q;
      min_d = min_acc_q;
    end
    if (start_period) begin
      max_acc_d = SAMPLE;
      min_acc_d = SAMPLE;
    end else if (acc_en) begin
      if (SAMPLE > max_acc_q) max_acc_d = SAMPLE;
      if (SAMPLE < min_acc_q) min_acc_d = SAMPLE;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      max_acc_q <= '0;
      min_acc_q <= '0;
      max_q     <= '0;
      min_q     <= '0;
    end else begin
      max_acc_q <= max_acc_d;
      min_acc_q <= min_acc_d;
      max_q     <= max_d;
      min_q     <= min_d;
    end
  end

  assign MAX = max_q;
  assign MIN = min_q;
`else
  assign MAX = '0;
  assign MIN = '0;
`endif

  assign PERIOD       = period_q;
  assign FORM         = form_q;
  assign RESULT_VALID = rv_q;
  assign LOCKED       = locked_q;

endmodule

// File: tb/tb_wave_meter.sv
// Scoreboard bench for wave_meter: stimulus pushes hand-computed results,
// a negedge monitor pops and compares on every RESULT_VALID pulse.
module tb_wave_meter;
  import wave_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  SAMPLE;
  logic        SAMPLE_VALID;
  logic [31:0] PERIOD;
  logic [2:0]  FORM;
  logic [7:0]  MAX, MIN;
  logic        RESULT_VALID, LOCKED;

  typedef struct {
    int id;
    int period;
    int form;
    int mx;
    int mn;
    int locked;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_compared   = 0;
  int   n_mismatched = 0;
  int   n_pushed     = 0;

  wave_meter #(.DATA_W(8), .CNT_W(32), .TIMEOUT(65536)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .SAMPLE       (SAMPLE),
    .SAMPLE_VALID (SAMPLE_VALID),
    .PERIOD       (PERIOD),
    .FORM         (FORM),
    .MAX          (MAX),
    .MIN          (MIN),
    .RESULT_VALID (RESULT_VALID),
    .LOCKED       (LOCKED)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_compared++;
    if (act !== req) begin
      n_mismatched++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // MAX/MIN read 0 when min/max tracking is compiled out.
  function automatic int mm(input int v);
`ifdef WAVE_METER_MINMAX_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic push(input int period, input form_e f, input int mx, input int mn, input int locked);
    exp_t e;
    e.id     = n_pushed;
    e.period = period;
    e.form   = int'(f);
    e.mx     = mm(mx);
    e.mn     = mm(mn);
    e.locked = locked;
    exp_q.push_back(e);
    n_pushed++;
  endtask

  always @(negedge CLK) begin
    if (RESET === 1'b0 && RESULT_VALID === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("result_without_expectation", exp_q.size(), 1);
      end else begin
        mon_e = exp_q.pop_front();
        check($sformatf("r%0d_period", mon_e.id), PERIOD, mon_e.period);
        check($sformatf("r%0d_form",   mon_e.id), FORM,   mon_e.form);
        check($sformatf("r%0d_max",    mon_e.id), MAX,    mon_e.mx);
        check($sformatf("r%0d_min",    mon_e.id), MIN,    mon_e.mn);
        check($sformatf("r%0d_locked", mon_e.id), LOCKED, mon_e.locked);
      end
    end
  end

  task automatic send(input logic [7:0] s);
    SAMPLE_VALID = 1'b1;
    SAMPLE       = s;
    @(posedge CLK);
    #1;
  endtask

  task automatic gap(input logic [7:0] s);
    SAMPLE_VALID = 1'b0;
    SAMPLE       = s;
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    SAMPLE_VALID = 1'b0;
    RESET        = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  task automatic drain(input string name);
    SAMPLE_VALID = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check({name, "_pending"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_period"}, PERIOD, 0);
    check({name, "_form"},   FORM,   3'b111);
    check({name, "_max"},    MAX,    0);
    check({name, "_min"},    MIN,    0);
    check({name, "_rv"},     RESULT_VALID, 0);
    check({name, "_locked"}, LOCKED, 0);
  endtask

  task automatic saw_lap(input bit toggle);
    for (int i = 0; i < 256; i++) begin
      send(8'(i));
      if (toggle) gap(~8'(i));
    end
  endtask

  task automatic rsaw_lap();
    for (int i = 255; i >= 0; i--) send(8'(i));
  endtask

  // 0,8..248 then 240..8: 62 samples per lap.
  task automatic tri_lap(input int count);
    for (int k = 0; k < count; k++) send(8'(k < 32 ? 8 * k : 8 * (62 - k)));
  endtask

  task automatic meander_lap(input int zeros, input int ones);
    for (int i = 0; i < zeros; i++) send(8'd0);
    for (int i = 0; i < ones; i++) send(8'd255);
  endtask

  initial begin
    RESET        = 1'b0;
    SAMPLE_VALID = 1'b0;
    SAMPLE       = '0;
    #1 RESET = 1'b1;
    #2;
    check_reset_state("por");
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;

    // Saw: first crossing arms, results from the 2nd crossing, lock on the 2nd result.
    push(256, FORM_SAW, 255, 0, 0);
    push(256, FORM_SAW, 255, 0, 1);
    push(256, FORM_SAW, 255, 0, 1);
    for (int l = 0; l < 4; l++) saw_lap(1'b0);
    check("saw_pending", exp_q.size(), 0);

    // Timeout: 127 saw samples already follow the last crossing.
    repeat (65408) send(8'd0);
    check("pre_timeout_locked", LOCKED, 1);
    check("pre_timeout_form", FORM, 3'b000);
    send(8'd0);
    check("timeout_locked", LOCKED, 0);
    check("timeout_form", FORM, 3'b111);
    repeat (127) send(8'd0);
    drain("timeout");

    // Reverse saw.
    apply_reset();
    push(256, FORM_RSAW, 255, 0, 0);
    push(256, FORM_RSAW, 255, 0, 1);
    push(256, FORM_RSAW, 255, 0, 1);
    for (int l = 0; l < 4; l++) rsaw_lap();
    send(8'd255);
    drain("rsaw");

    // Triangle, then reset mid-period and re-acquire.
    apply_reset();
    push(62, FORM_TRI, 248, 0, 0);
    push(62, FORM_TRI, 248, 0, 1);
    push(62, FORM_TRI, 248, 0, 1);
    for (int l = 0; l < 4; l++) tri_lap(62);
    tri_lap(10);
    drain("tri");
    check("pre_midrst_period", PERIOD, 62);
    #2 RESET = 1'b1;
    #1;
    check_reset_state("midrst");
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    push(62, FORM_TRI, 248, 0, 0);
    push(62, FORM_TRI, 248, 0, 1);
    for (int l = 0; l < 3; l++) tri_lap(62);
    drain("tri_after_rst");

    // Meander, then switch to 25 % duty: one transitional 80-sample period.
    apply_reset();
    push(64, FORM_MEANDER, 255, 0, 0);
    push(64, FORM_MEANDER, 255, 0, 1);
    push(64, FORM_MEANDER, 255, 0, 1);
    push(80, FORM_UNKNOWN, 255, 0, 0);
    push(64, FORM_MEANDER025, 255, 0, 0);
    push(64, FORM_MEANDER025, 255, 0, 1);
    for (int l = 0; l < 4; l++) meander_lap(32, 32);
    for (int l = 0; l < 3; l++) meander_lap(48, 16);
    drain("meander");

    // Short periods: N=2 is always unknown; N=4, H=1 just meets the 25 % rule.
    apply_reset();
    push(2, FORM_UNKNOWN, 200, 0, 0);
    push(2, FORM_UNKNOWN, 200, 0, 0);
    push(2, FORM_UNKNOWN, 200, 0, 0);
    for (int l = 0; l < 4; l++) begin
      send(8'd0);
      send(8'd200);
    end
    push(4, FORM_MEANDER025, 200, 0, 0);
    push(4, FORM_MEANDER025, 255, 0, 1);
    push(4, FORM_MEANDER025, 255, 0, 1);
    push(4, FORM_MEANDER025, 255, 0, 1);
    for (int l = 0; l < 4; l++) meander_lap(3, 1);
    drain("short");

    // Saw with SAMPLE_VALID low every other cycle and junk on SAMPLE meanwhile.
    apply_reset();
    push(256, FORM_SAW, 255, 0, 0);
    push(256, FORM_SAW, 255, 0, 1);
    push(256, FORM_SAW, 255, 0, 1);
    for (int l = 0; l < 4; l++) saw_lap(1'b1);
    drain("saw_gaps");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/wave_meter.md
WAVE_METER -- requirements
Module: wave_meter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, sample width (unsigned).
REQ-002 SHALL have parameter CNT_W, default 32, period/duty counter width.
REQ-003 SHALL have parameter TIMEOUT, default 65536, valid samples without a crossing before lock loss.
REQ-004 SHALL have port CLK  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port SAMPLE  input  DATA_W  waveform sample from the DDS shaper.
REQ-007 SHALL have port SAMPLE_VALID  input  1  SAMPLE qualifier; all counting in valid samples.
REQ-008 SHALL have port PERIOD  output  CNT_W  valid samples between the last two crossings.
REQ-009 SHALL have port FORM  output  3  classified waveform: 000 saw, 001 reverse saw, 010 triangle, 011 meander, 100 meander 25 %, 111 unknown.
REQ-010 SHALL have port MAX  output  DATA_W  largest sample in the last period.
REQ-011 SHALL have port MIN  output  DATA_W  smallest sample in the last period.
REQ-012 SHALL have port RESULT_VALID  output  1  one-cycle pulse when PERIOD/FORM/MAX/MIN update.
REQ-013 SHALL have port LOCKED  output  1  high while two consecutive results carry the same non-111 FORM.

Function
REQ-014 SHALL define a crossing as a valid sample with prev < 2^(DATA_W-1) and SAMPLE >= 2^(DATA_W-1), prev being the previous valid sample.
REQ-015 SHALL define delta = SAMPLE - prev (signed DATA_W+1); jump: |delta| >= 2^(DATA_W-2); small up: 0 < delta < 2^(DATA_W-2); small down: symmetric; delta 0 not counted.
REQ-016 SHALL accumulate per period: sample count N, high count H (SAMPLE >= midpoint), small-up U, small-down D, up-jumps JU, down-jumps JD, running max/min; the crossing sample starts the next period.
REQ-017 SHALL classify: U=0,D=0 and |2H-N| <= N/8 -> 011; U=0,D=0 and |4H-N| <= N/8 -> 100; U>0,D>0,JU=JD=0 -> 010; U>0,D=0,JD=1 -> 000; D>0,U=0,JU=1 -> 001; else 111.
REQ-018 SHALL register outputs and pulse RESULT_VALID in the cycle after the crossing sample is accepted (latency 1 clock).
REQ-019 SHALL use states IDLE (no prev) -> ARMED (prev held, awaiting first crossing) -> MEASURE; first crossing in ARMED enters MEASURE without a result.
REQ-020 SHALL report FORM 111 when N < 4, still updating PERIOD.
REQ-021 SHALL saturate N, H, U, D at 2^CNT_W-1 and JU/JD at 3, never wrapping.
REQ-022 SHALL, after TIMEOUT valid samples in MEASURE without a crossing, drop LOCKED, set FORM 111, return to ARMED, no RESULT_VALID.
REQ-023 SHALL hold all state when SAMPLE_VALID is low.

Reset
REQ-024 SHALL on RESET force state IDLE, PERIOD 0, FORM 111, MAX 0, MIN 0, RESULT_VALID 0, LOCKED 0, all accumulators 0, immediately and regardless of CLK.
REQ-025 SHALL, on reset mid-period, discard the partial period and require a new first crossing.

Configuration
REQ-026 SHALL honour macro WAVE_METER_MINMAX_EN: defined -> MAX/MIN tracked per REQ-016; undefined -> MAX/MIN tied to 0, tracking logic absent, classification unchanged.

Structure
REQ-027 SHALL place FORM codes (FORM_SAW, FORM_RSAW, FORM_TRI, FORM_MEANDER, FORM_MEANDER025, FORM_UNKNOWN) and state encodings in package wave_pkg, shared with form_wave users.
REQ-028 SHALL isolate REQ-017 decision logic in combinational sub-module wave_classify (inputs N,H,U,D,JU,JD; output FORM).

Verification
REQ-029 SHALL cover: saw 0..255 step 1, continuous valid -> from 2nd crossing PERIOD 256, FORM 000, MAX 255, MIN 0; LOCKED after 2nd result.
REQ-030 SHALL cover: reverse saw 255..0 step 1 -> PERIOD 256, FORM 001.
REQ-031 SHALL cover: triangle 0,8..248,240..8 repeating -> PERIOD 62, FORM 010, MAX 248, MIN 0.
REQ-032 SHALL cover: 32x0 then 32x255 -> PERIOD 64, FORM 011; 48x0 then 16x255 -> PERIOD 64, FORM 100; switching loses then regains LOCKED.
REQ-033 SHALL cover: constant 0 for 65536 valid samples after lock -> LOCKED 0, FORM 111, no RESULT_VALID; RESET mid-period -> all outputs per REQ-024 same cycle.
REQ-034 SHALL cover: SAMPLE_VALID toggling every other cycle on saw input -> identical PERIOD 256, FORM 000.
